// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: 1-cycle latency, no id_* to ex_* combinational path.
// Priority per edge: reset > flush (clears everything) > freeze (hold) > load.
module id_ex_stage_reg #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [WORD_W-1:0]     id_pc,
  input  logic [WORD_W-1:0]     id_val_rn,
  input  logic [WORD_W-1:0]     id_val_rm,
  input  logic [11:0]           id_shift_operand,
  input  logic                  id_imm,
  input  logic [23:0]           id_signed_imm_24,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [3:0]            id_exe_cmd,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic                  id_wb_en,
  input  logic                  id_b,
  input  logic                  id_s,
  input  logic                  id_carry,
  output logic                  ex_valid,
  output logic [WORD_W-1:0]     ex_pc,
  output logic [WORD_W-1:0]     ex_val_rn,
  output logic [WORD_W-1:0]     ex_val_rm,
  output logic [11:0]           ex_shift_operand,
  output logic                  ex_imm,
  output logic [23:0]           ex_signed_imm_24,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
  output logic [3:0]            ex_exe_cmd,
  output logic                  ex_mem_r_en,
  output logic                  ex_mem_w_en,
  output logic                  ex_wb_en,
  output logic                  ex_b,
  output logic                  ex_s,
  output logic                  ex_carry,
  output logic                  ex_mem_sel
);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      // Squashed entries clear datapath fields too so EX sees deterministic inputs.
      ex_valid         <= 1'b0;
      ex_pc            <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_shift_operand <= '0;
      ex_imm           <= 1'b0;
      ex_signed_imm_24 <= '0;
      ex_dest          <= '0;
      ex_src1          <= '0;
      ex_src2          <= '0;
      ex_exe_cmd       <= 4'b0000;
      ex_mem_r_en      <= 1'b0;
      ex_mem_w_en      <= 1'b0;
      ex_wb_en         <= 1'b0;
      ex_b             <= 1'b0;
      ex_s             <= 1'b0;
      ex_carry         <= 1'b0;
    end else if (!freeze) begin
      ex_valid         <= id_valid;
      ex_pc            <= id_pc;
      ex_val_rn        <= id_val_rn;
      ex_val_rm        <= id_val_rm;
      ex_shift_operand <= id_shift_operand;
      ex_imm           <= id_imm;
      ex_signed_imm_24 <= id_signed_imm_24;
      ex_dest          <= id_dest;
      ex_src1          <= id_src1;
      ex_src2          <= id_src2;
      ex_exe_cmd       <= id_exe_cmd;
      ex_carry         <= id_carry;
      // A bubble may carry stale control bits; gate them so it has no side effects.
      ex_mem_r_en      <= id_mem_r_en & id_valid;
      ex_mem_w_en      <= id_mem_w_en & id_valid;
      ex_wb_en         <= id_wb_en    & id_valid;
      ex_b             <= id_b        & id_valid;
      ex_s             <= id_s        & id_valid;
    end
  end

  assign ex_mem_sel = ex_mem_r_en | ex_mem_w_en;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the decode (ID) stage and the execute (EX) stage of the 5-stage ARM core.
- Captures decoded control signals, register-file operands and immediate fields each cycle.
- Presents them to EX, where they drive the Val2 generator (rm, shift_operand, imm, mem-access select), the ALU and branch-target adder.
- Supports freeze (hold) for hazard or memory stalls, and flush for a taken branch. Tracks a valid bit.

Parameters:
- WORD_W, 32, datapath and PC width
- REG_ADDR_W, 4, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset; state clears on the rising clk edge while rst==0
- freeze  in  1  hold all stored state this cycle
- flush  in  1  squash the instruction being captured (taken branch in EX)
- id_valid  in  1  ID holds a real instruction
- id_pc  in  WORD_W  PC+4 of the ID instruction
- id_val_rn, id_val_rm  in  WORD_W  register-file read data
- id_shift_operand  in  12  instruction bits [11:0]
- id_imm  in  1  I bit
- id_signed_imm_24  in  24  branch offset
- id_dest, id_src1, id_src2  in  REG_ADDR_W  destination and source register numbers
- id_exe_cmd  in  4  ALU command
- id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s  in  1 each  control bits
- id_carry  in  1  status C flag sampled in ID
- ex_* (one per id_* field above, same width)  out  registered copies
- ex_valid  out  1  EX holds a real instruction
- ex_mem_sel  out  1  =ex_mem_r_en|ex_mem_w_en; Val2 select input

Behaviour:
- All outputs are registered. Latency is 1 cycle from id_* to ex_*. ex_mem_sel is a combinational OR of two registered bits.
- Reset (rst==0 at a clk edge): every ex_* output = 0, ex_valid=0, ex_mem_sel=0. Reset overrides flush and freeze.
- Priority at each edge with rst==1: flush > freeze > load.
- Load (flush==0, freeze==0):
  - All ex_* take the id_* values.
  - ex_valid=id_valid.
  - If id_valid==0, the control bits ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_b, ex_s are forced 0. Datapath fields still load.
- Freeze (flush==0, freeze==1): every register holds its value, including ex_valid.
- Flush (flush==1):
  - ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_b, ex_s are cleared to 0.
  - ex_exe_cmd is cleared to 4'b0000.
  - Datapath fields (pc, val_rn, val_rm, shift_operand, imm, signed_imm_24, dest, src1, src2, carry) are cleared to 0, so the EX inputs are deterministic.
  - Flush takes effect even when freeze==1 in the same cycle.
- A squashed or bubble entry must never cause a memory access, writeback, branch or status update. This is guaranteed by its cleared control bits.
- Widths are fixed pass-through, with no sign extension here. Sign extension of signed_imm_24 happens in EX.
- No combinational path from any id_* input to any ex_* output.
- Freeze held for N cycles keeps the outputs stable for N cycles. The first edge after freeze drops loads the then-current id_* values.

Test Plan:
- Reset: rst=0 for 2 edges with id_* at arbitrary nonzero values -> all ex_* = 0, ex_valid=0. Release rst, id_valid=1, id_exe_cmd=4'b0010, id_val_rm=32'h0000_00F0, id_shift_operand=12'h184 -> ex_exe_cmd=2, ex_val_rm=32'hF0, ex_shift_operand=12'h184 after exactly 1 edge.
- Load stream: 4 back-to-back instructions with id_pc=4,8,12,16 -> ex_pc=4,8,12,16 on consecutive edges; ex_valid=1 throughout.
- Freeze: after ex_pc=8, freeze=1 for 3 edges while id_pc=12 -> ex_pc stays 8 for those 3 edges, then becomes 12 on the first edge after freeze=0.
- Flush: ex holds an instruction with wb_en=1, mem_w_en=1; assert flush=1 for 1 edge -> ex_valid=0, ex_wb_en=0, ex_mem_w_en=0, ex_mem_sel=0, ex_exe_cmd=0.
- Flush+freeze in the same cycle -> result identical to flush alone. A next-cycle load with id_pc=20 gives ex_pc=20.
- Bubble: id_valid=0 with id_wb_en=1, id_mem_r_en=1 -> ex_valid=0, ex_wb_en=0, ex_mem_r_en=0, ex_mem_sel=0. Reset asserted mid-freeze also clears all outputs.
